// File: rtl/aud_transport_ctrl.sv
// rtl/aud_transport_ctrl.sv - record/play transport controller with per-slot end-address tracking
// Sequences codec init, issues one-cycle recorder/DSP command pulses and steers the SRAM.
module aud_transport_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_fin,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [SLOT_W-1:0] i_slot_sel,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_init_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_slot_base,
  output logic              o_sram_sel_rec,
  output logic              o_sram_we_n,
  output logic [2:0]        o_state,
  output logic [SLOT_W-1:0] o_slot
);

  localparam int OFF_W = ADDR_W - SLOT_W;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5,
    S_RELOOP     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                init_sent_q, init_sent_d;
  logic                init_start_q, init_start_d;
  logic                rec_start_q, rec_start_d;
  logic                rec_pause_q, rec_pause_d;
  logic                rec_stop_q, rec_stop_d;
  logic                dsp_start_q, dsp_start_d;
  logic                dsp_pause_q, dsp_pause_d;
  logic                dsp_stop_q, dsp_stop_d;
  logic                sram_we_n_q, sram_we_n_d;
  logic                sram_sel_rec_q, sram_sel_rec_d;
  logic [ADDR_W-1:0]   end_q [NUM_SLOTS];
  logic [ADDR_W-1:0]   end_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;

  logic              key_stop, key_rec, key_play;
  logic [ADDR_W-1:0] slot_base;
  logic              slot_full, commit_ok, play_end, rec_end;

  // Single winner per cycle: stop beats rec beats play.
  assign key_stop = i_key_stop;
  assign key_rec  = i_key_rec & ~i_key_stop;
  assign key_play = i_key_play & ~i_key_rec & ~i_key_stop;

  assign slot_base = {slot_q, {OFF_W{1'b0}}};
  assign slot_full = (i_rec_addr == {slot_q, {OFF_W{1'b1}}});
  assign commit_ok = (i_rec_addr != slot_base);
  assign play_end  = (i_play_addr >= end_q[slot_q]);
  // Any of these closes the take; a full slot outranks a pause request.
  assign rec_end   = key_stop | key_play | ((state_q == S_RECD) & slot_full);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    init_sent_d  = init_sent_q;
    end_d        = end_q;
    valid_d      = valid_q;
    init_start_d = 1'b0;
    rec_start_d  = 1'b0;
    rec_pause_d  = 1'b0;
    rec_stop_d   = 1'b0;
    dsp_start_d  = 1'b0;
    dsp_pause_d  = 1'b0;
    dsp_stop_d   = 1'b0;

    case (state_q)
      S_INIT: begin
        if (!init_sent_q) begin
          init_start_d = 1'b1;
          init_sent_d  = 1'b1;
        end else if (i_init_fin) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (key_rec) begin
          slot_d              = i_slot_sel;
          valid_d[i_slot_sel] = 1'b0;
          rec_start_d         = 1'b1;
          state_d             = S_RECD;
        end else if (key_play) begin
          slot_d = i_slot_sel;
          if (valid_q[i_slot_sel]) begin
            dsp_start_d = 1'b1;
            state_d     = S_PLAY;
          end
        end
      end

      S_RECD, S_RECD_PAUSE: begin
        if (rec_end) begin
          rec_stop_d      = 1'b1;
          end_d[slot_q]   = i_rec_addr;
          valid_d[slot_q] = commit_ok;
          state_d         = S_IDLE;
          if (key_play && commit_ok) begin
            dsp_start_d = 1'b1;
            state_d     = S_PLAY;
          end
        end else if (key_rec) begin
          if (state_q == S_RECD) begin
            rec_pause_d = 1'b1;
            state_d     = S_RECD_PAUSE;
          end else begin
            rec_start_d = 1'b1;
            state_d     = S_RECD;
          end
        end
      end

      S_PLAY, S_PLAY_PAUSE: begin
        if (key_rec) begin
          dsp_stop_d      = 1'b1;
          rec_start_d     = 1'b1;
          valid_d[slot_q] = 1'b0;
          state_d         = S_RECD;
        end else if (key_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = S_IDLE;
        end else if (key_play) begin
          if (state_q == S_PLAY) begin
            dsp_pause_d = 1'b1;
            state_d     = S_PLAY_PAUSE;
          end else begin
            dsp_start_d = 1'b1;
            state_d     = S_PLAY;
          end
        end else if ((state_q == S_PLAY) && play_end) begin
          dsp_stop_d = 1'b1;
          state_d    = i_loop ? S_RELOOP : S_IDLE;
        end
      end

      S_RELOOP: begin
        dsp_start_d = 1'b1;
        state_d     = S_PLAY;
      end

      default: state_d = S_INIT;
    endcase

    sram_we_n_d    = (state_d != S_RECD);
    sram_sel_rec_d = (state_d == S_RECD) || (state_d == S_RECD_PAUSE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_INIT;
      slot_q         <= '0;
      init_sent_q    <= 1'b0;
      init_start_q   <= 1'b0;
      rec_start_q    <= 1'b0;
      rec_pause_q    <= 1'b0;
      rec_stop_q     <= 1'b0;
      dsp_start_q    <= 1'b0;
      dsp_pause_q    <= 1'b0;
      dsp_stop_q     <= 1'b0;
      sram_we_n_q    <= 1'b1;
      sram_sel_rec_q <= 1'b0;
      valid_q        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) end_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      init_sent_q    <= init_sent_d;
      init_start_q   <= init_start_d;
      rec_start_q    <= rec_start_d;
      rec_pause_q    <= rec_pause_d;
      rec_stop_q     <= rec_stop_d;
      dsp_start_q    <= dsp_start_d;
      dsp_pause_q    <= dsp_pause_d;
      dsp_stop_q     <= dsp_stop_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_sel_rec_q <= sram_sel_rec_d;
      valid_q        <= valid_d;
      end_q          <= end_d;
    end
  end

  assign o_init_start   = init_start_q;
  assign o_rec_start    = rec_start_q;
  assign o_rec_pause    = rec_pause_q;
  assign o_rec_stop     = rec_stop_q;
  assign o_dsp_start    = dsp_start_q;
  assign o_dsp_pause    = dsp_pause_q;
  assign o_dsp_stop     = dsp_stop_q;
  assign o_slot_base    = slot_base;
  assign o_sram_sel_rec = sram_sel_rec_q;
  assign o_sram_we_n    = sram_we_n_q;
  assign o_state        = state_q;
  assign o_slot         = slot_q;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
// tb/tb_aud_transport_ctrl.sv - scoreboard bench for aud_transport_ctrl
// Directed transport scenarios followed by randomized key/address traffic against a reference model.
module tb_aud_transport_ctrl;

  localparam int ADDR_W = 20;
  localparam int SLOTS  = 4;
  localparam int SZ     = 1 << 18;
  localparam int OUT_W  = 34;

  localparam int ST_INIT = 0, ST_IDLE = 1, ST_RECD = 2, ST_RPAUSE = 3;
  localparam int ST_PLAY = 4, ST_PPAUSE = 5, ST_RELOOP = 6;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_init_fin = 1'b0;
  logic              i_key_rec = 1'b0, i_key_play = 1'b0, i_key_stop = 1'b0;
  logic [1:0]        i_slot_sel = '0;
  logic              i_loop = 1'b0;
  logic [ADDR_W-1:0] i_rec_addr = '0, i_play_addr = '0;

  logic              o_init_start, o_rec_start, o_rec_pause, o_rec_stop;
  logic              o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [ADDR_W-1:0] o_slot_base;
  logic              o_sram_sel_rec, o_sram_we_n;
  logic [2:0]        o_state;
  logic [1:0]        o_slot;

  aud_transport_ctrl #(.ADDR_W(ADDR_W), .NUM_SLOTS(SLOTS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_init_fin(i_init_fin),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
    .i_slot_sel(i_slot_sel), .i_loop(i_loop),
    .i_rec_addr(i_rec_addr), .i_play_addr(i_play_addr),
    .o_init_start(o_init_start), .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
    .o_rec_stop(o_rec_stop), .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
    .o_dsp_stop(o_dsp_stop), .o_slot_base(o_slot_base), .o_sram_sel_rec(o_sram_sel_rec),
    .o_sram_we_n(o_sram_we_n), .o_state(o_state), .o_slot(o_slot)
  );

  always #5 clk = ~clk;

  // Reference model: what the transport should look like after each edge.
  int          m_state = ST_INIT;
  int          m_slot = 0;
  bit          m_init_sent = 0;
  int unsigned m_end [SLOTS];
  bit          m_valid [SLOTS];

  logic [OUT_W-1:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic model_step();
    bit s, r, p, full, ok;
    int unsigned base, ra, pa;
    bit in_st, rs, rp, rt, ds, dp, dt;
    logic [OUT_W-1:0] e;
    {in_st, rs, rp, rt, ds, dp, dt} = '0;
    ra = i_rec_addr;
    pa = i_play_addr;
    if (i_rst) begin
      m_state = ST_INIT; m_slot = 0; m_init_sent = 0;
      for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
    end else begin
      s = i_key_stop;
      r = i_key_rec && !s;
      p = i_key_play && !s && !r;
      base = m_slot * SZ;
      full = (ra == base + SZ - 1);
      ok   = (ra != base);
      if (m_state == ST_INIT) begin
        if (!m_init_sent) begin in_st = 1; m_init_sent = 1; end
        else if (i_init_fin) m_state = ST_IDLE;
      end else if (m_state == ST_IDLE) begin
        if (r) begin
          m_slot = i_slot_sel; m_valid[m_slot] = 0; rs = 1; m_state = ST_RECD;
        end else if (p) begin
          m_slot = i_slot_sel;
          if (m_valid[m_slot]) begin ds = 1; m_state = ST_PLAY; end
        end
      end else if (m_state == ST_RECD || m_state == ST_RPAUSE) begin
        if (s || p || (m_state == ST_RECD && full)) begin
          rt = 1; m_end[m_slot] = ra; m_valid[m_slot] = ok;
          m_state = (p && ok) ? ST_PLAY : ST_IDLE;
          ds = p && ok;
        end else if (r) begin
          if (m_state == ST_RECD) begin rp = 1; m_state = ST_RPAUSE; end
          else begin rs = 1; m_state = ST_RECD; end
        end
      end else if (m_state == ST_PLAY || m_state == ST_PPAUSE) begin
        if (r) begin
          dt = 1; rs = 1; m_valid[m_slot] = 0; m_state = ST_RECD;
        end else if (s) begin
          dt = 1; m_state = ST_IDLE;
        end else if (p) begin
          if (m_state == ST_PLAY) begin dp = 1; m_state = ST_PPAUSE; end
          else begin ds = 1; m_state = ST_PLAY; end
        end else if (m_state == ST_PLAY && pa >= m_end[m_slot]) begin
          dt = 1; m_state = i_loop ? ST_RELOOP : ST_IDLE;
        end
      end else begin
        ds = 1; m_state = ST_PLAY;
      end
    end
    e = {3'(m_state), 2'(m_slot), 20'(m_slot * SZ), in_st, rs, rp, rt, ds, dp, dt,
         (m_state != ST_RECD), (m_state == ST_RECD || m_state == ST_RPAUSE)};
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit r, input bit p, input bit s);
    @(negedge clk);
    i_key_rec = r; i_key_play = p; i_key_stop = s;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  // Monitor: every edge that has an expectation queued is checked.
  always @(posedge clk) begin
    logic [OUT_W-1:0] e, a;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_state, o_slot, o_slot_base, o_init_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_sram_we_n, o_sram_sel_rec};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got st=%0d slot=%0d base=%05h pulses=%07b we_n=%b sel=%b, want st=%0d slot=%0d base=%05h pulses=%07b we_n=%b sel=%b",
                 cyc, a[33:31], a[30:29], a[28:9], a[8:2], a[1], a[0],
                 e[33:31], e[30:29], e[28:9], e[8:2], e[1], e[0]);
      end
    end
  end

  initial begin
    int unsigned base;
    for (int i = 0; i < SLOTS; i++) begin m_end[i] = 0; m_valid[i] = 0; end

    // Reset, long init wait with keys that must be ignored.
    i_rst = 1; idle(2);
    i_rst = 0; i_init_fin = 0;
    for (int i = 0; i < 50; i++) tick(i % 7 == 1, i % 5 == 2, i % 11 == 3);
    i_init_fin = 1; idle(3);

    // Record slot 2 to 0x80400, then play to its end without looping.
    i_loop = 0; i_slot_sel = 2; i_rec_addr = 20'h80000;
    tick(1, 0, 0);
    for (int i = 1; i <= 3; i++) begin i_rec_addr = 20'h80000 + 20'(i * 256); idle(1); end
    i_rec_addr = 20'h80400; tick(0, 0, 1);
    i_play_addr = 20'h80000; tick(0, 1, 0);
    idle(4);
    i_play_addr = 20'h80400; idle(3);

    // Same take, looping.
    i_loop = 1; i_play_addr = 20'h80000; tick(0, 1, 0);
    idle(3);
    i_play_addr = 20'h80400; idle(1);
    i_play_addr = 20'h80000; idle(3);
    tick(0, 0, 1);
    i_loop = 0;

    // Slot 1 fills to its last word; slot 3 was never recorded.
    i_slot_sel = 1; i_rec_addr = 20'h40000; tick(1, 0, 0);
    i_rec_addr = 20'h50000; idle(2);
    i_rec_addr = 20'h7FFFF; idle(2);
    i_slot_sel = 3; tick(0, 1, 0);
    idle(2);

    // Simultaneous keys in PLAY, then rec while playing.
    i_slot_sel = 2; i_play_addr = 20'h80000; tick(0, 1, 0);
    idle(2);
    tick(1, 1, 1);
    tick(0, 1, 0);
    idle(1);
    tick(1, 0, 0);
    i_rec_addr = 20'h80010; idle(1);
    tick(0, 0, 1);

    // Reset while recording.
    i_rec_addr = 20'h80000; tick(1, 0, 0);
    i_rec_addr = 20'h80020; idle(2);
    i_rst = 1; idle(1);
    i_rst = 0; i_init_fin = 0; idle(3);
    i_init_fin = 1; idle(3);
    tick(0, 1, 0);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      i_rst      = ($urandom_range(0, 599) == 0);
      i_init_fin = ($urandom_range(0, 3) == 0);
      i_slot_sel = 2'($urandom_range(0, 3));
      i_loop     = 1'($urandom_range(0, 1));
      base = m_slot * SZ;
      case ($urandom_range(0, 15))
        0:       i_rec_addr = 20'(base + SZ - 1);
        1:       i_rec_addr = 20'(base);
        default: i_rec_addr = 20'(base + $urandom_range(1, 4095));
      endcase
      if ($urandom_range(0, 7) == 0) i_play_addr = 20'(m_end[m_slot]);
      else i_play_addr = 20'(base + $urandom_range(0, 4400));
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    i_rst = 0;
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
